sensor_vote_monitor: RTL and testbench

Parametrised N-sensor k-of-N voting monitor, successor to the fixed seven-sensor "fewer than six active" product-of-sums detector. It debounces each sensor input and keeps a registered active-sensor count. It drives the legacy-polarity OK flag `f`, which is 1 while the count is below THRESHOLD. It also provides a sticky alarm and a saturating trip-event counter. It sits between the raw sensor pins and the supervisory logic.

---
 rtl/sensor_vote_monitor.sv | 116 +++++++++++
 tb/tb_sensor_vote_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sensor_vote_monitor.sv
// k-of-N sensor voting monitor: per-sensor debounce, registered active count,
// legacy-polarity OK flag, sticky alarm and saturating trip-event counter.
module sensor_vote_monitor #(
  parameter int N_SENSORS = 7,
  parameter int THRESHOLD = 6,
  parameter int DEBOUNCE  = 4,
  parameter int EVW       = 8,
  localparam int CW       = $clog2(N_SENSORS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] X,
  input  logic                 clear,
  output logic                 f,
  output logic                 alarm,
  output logic [CW-1:0]        count,
  output logic [N_SENSORS-1:0] stable,
  output logic [EVW-1:0]       events
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0]  DMAX   = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  TH     = CW'(THRESHOLD);
  localparam logic [EVW-1:0] EV_MAX = '1;

  if (N_SENSORS < 2 || N_SENSORS > 32) begin : g_bad_n
    $error("sensor_vote_monitor: N_SENSORS must be 2..32");
  end
  if (THRESHOLD < 1 || THRESHOLD > N_SENSORS) begin : g_bad_th
    $error("sensor_vote_monitor: THRESHOLD must be 1..N_SENSORS");
  end
  if (DEBOUNCE < 1) begin : g_bad_db
    $error("sensor_vote_monitor: DEBOUNCE must be >= 1");
  end
  if (EVW < 1) begin : g_bad_evw
    $error("sensor_vote_monitor: EVW must be >= 1");
  end

  logic [N_SENSORS-1:0] xs;
  logic [DW-1:0]        cnt [N_SENSORS];
  logic [CW-1:0]        pop;
  logic                 trip;
  logic                 f_prev;
  logic                 fall;

  // X is asynchronous; one sample stage before any decision is made on it
  always_ff @(posedge clk) begin
    if (reset) begin
      xs <= '0;
    end else begin
      xs <= X;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < N_SENSORS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (xs[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DMAX) begin
          stable[i] <= xs[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      pop = pop + CW'(stable[i]);
    end
  end

  assign trip = (pop >= TH);
  assign fall = f_prev & ~f;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      f      <= 1'b1;
      f_prev <= 1'b1;
    end else begin
      count  <= pop;
      f      <= ~trip;
      f_prev <= f;
    end
  end

  // a trip in progress always wins over an acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm <= 1'b0;
    end else if (!f) begin
      alarm <= 1'b1;
    end else if (clear) begin
      alarm <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      events <= '0;
    end else if (fall && events != EV_MAX) begin
      events <= events + 1'b1;
    end
  end

endmodule

// File: tb/tb_sensor_vote_monitor.sv
// Table-driven bench for sensor_vote_monitor: default build plus a
// 16-sensor / DEBOUNCE=1 / EVW=2 build for latency and saturation.
module tb_sensor_vote_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  x0 = '0;
  logic [15:0] x1 = '0;

  logic        f0, alarm0;
  logic [2:0]  count0;
  logic [6:0]  stable0;
  logic [7:0]  events0;

  logic        f1, alarm1;
  logic [4:0]  count1;
  logic [15:0] stable1;
  logic [1:0]  events1;

  always #5 clk = ~clk;

  sensor_vote_monitor dut0 (
    .clk    (clk),
    .reset  (reset),
    .X      (x0),
    .clear  (clear),
    .f      (f0),
    .alarm  (alarm0),
    .count  (count0),
    .stable (stable0),
    .events (events0)
  );

  sensor_vote_monitor #(
    .N_SENSORS(16),
    .THRESHOLD(10),
    .DEBOUNCE (1),
    .EVW      (2)
  ) dut1 (
    .clk    (clk),
    .reset  (reset),
    .X      (x1),
    .clear  (clear),
    .f      (f1),
    .alarm  (alarm1),
    .count  (count1),
    .stable (stable1),
    .events (events1)
  );

  typedef struct {
    bit          sel;
    bit          rst;
    bit          clr;
    logic [31:0] x;
    logic        f;
    logic        al;
    logic [5:0]  cnt;
    logic [7:0]  ev;
    logic [31:0] st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int n, bit sel, bit rst, bit clr,
                              logic [31:0] x, bit f, bit al,
                              int cnt, int ev, logic [31:0] st);
    vec_t v;
    v.sel = sel;
    v.rst = rst;
    v.clr = clr;
    v.x   = x;
    v.f   = f;
    v.al  = al;
    v.cnt = 6'(cnt);
    v.ev  = 8'(ev);
    v.st  = st;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic check(string name, int row,
                       logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               name, row, act, exp);
    end
  endtask

  initial begin
    vec_t r, e;
    int   ev;
    int   evn;

    // reset with all sensors asserted
    add(2, 0, 1, 0, 32'h7F, 1, 0, 0, 0, 32'h00);
    add(1, 0, 0, 0, 32'h7F, 1, 0, 0, 0, 32'h00);
    add(3, 0, 0, 0, 32'h00, 1, 0, 0, 0, 32'h00);
    // step to six active: exactly THRESHOLD trips
    add(4, 0, 0, 0, 32'h3F, 1, 0, 0, 0, 32'h00);
    add(1, 0, 0, 0, 32'h3F, 1, 0, 0, 0, 32'h3F);
    add(1, 0, 0, 0, 32'h3F, 0, 0, 6, 0, 32'h3F);
    add(3, 0, 0, 0, 32'h3F, 0, 1, 6, 1, 32'h3F);
    // THRESHOLD-1 releases f, alarm sticks
    add(4, 0, 0, 0, 32'h1F, 0, 1, 6, 1, 32'h3F);
    add(1, 0, 0, 0, 32'h1F, 0, 1, 6, 1, 32'h1F);
    add(3, 0, 0, 0, 32'h1F, 1, 1, 5, 1, 32'h1F);
    // acknowledge with f=1
    add(1, 0, 0, 1, 32'h1F, 1, 0, 5, 1, 32'h1F);
    add(1, 0, 0, 0, 32'h1F, 1, 0, 5, 1, 32'h1F);
    add(4, 0, 0, 0, 32'h00, 1, 0, 5, 1, 32'h1F);
    add(1, 0, 0, 0, 32'h00, 1, 0, 5, 1, 32'h00);
    add(2, 0, 0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
    // 3-cycle glitch is rejected
    add(3, 0, 0, 0, 32'h7F, 1, 0, 0, 1, 32'h00);
    add(6, 0, 0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
    // 4-cycle pulse gets through
    add(4, 0, 0, 0, 32'h7F, 1, 0, 0, 1, 32'h00);
    add(1, 0, 0, 0, 32'h00, 1, 0, 0, 1, 32'h7F);
    add(1, 0, 0, 0, 32'h00, 0, 0, 7, 1, 32'h7F);
    add(2, 0, 0, 0, 32'h00, 0, 1, 7, 2, 32'h7F);
    add(1, 0, 0, 0, 32'h00, 0, 1, 7, 2, 32'h00);
    add(3, 0, 0, 0, 32'h00, 1, 1, 0, 2, 32'h00);
    // clear held through a trip: set wins
    add(4, 0, 0, 1, 32'h7F, 1, 0, 0, 2, 32'h00);
    add(1, 0, 0, 1, 32'h7F, 1, 0, 0, 2, 32'h7F);
    add(1, 0, 0, 1, 32'h7F, 0, 0, 7, 2, 32'h7F);
    add(3, 0, 0, 1, 32'h7F, 0, 1, 7, 3, 32'h7F);
    add(4, 0, 0, 1, 32'h00, 0, 1, 7, 3, 32'h7F);
    add(1, 0, 0, 1, 32'h00, 0, 1, 7, 3, 32'h00);
    add(1, 0, 0, 1, 32'h00, 1, 1, 0, 3, 32'h00);
    add(2, 0, 0, 1, 32'h00, 1, 0, 0, 3, 32'h00);
    add(2, 0, 0, 0, 32'h00, 1, 0, 0, 3, 32'h00);
    // reset in the middle of a debounce
    add(2, 0, 0, 0, 32'h7F, 1, 0, 0, 3, 32'h00);
    add(1, 0, 1, 0, 32'h7F, 1, 0, 0, 0, 32'h00);
    add(4, 0, 0, 0, 32'h7F, 1, 0, 0, 0, 32'h00);
    add(1, 0, 0, 0, 32'h7F, 1, 0, 0, 0, 32'h7F);
    add(1, 0, 0, 0, 32'h7F, 0, 0, 7, 0, 32'h7F);
    add(2, 0, 0, 0, 32'h7F, 0, 1, 7, 1, 32'h7F);
    add(1, 0, 1, 0, 32'h00, 1, 0, 0, 0, 32'h00);

    // 16-sensor build: five trip/untrip cycles
    add(2, 1, 1, 0, 32'h0, 1, 0, 0, 0, 32'h0);
    ev = 0;
    for (int c = 0; c < 5; c++) begin
      evn = (ev < 3) ? ev + 1 : 3;
      if (c == 0) begin
        add(1, 1, 0, 0, 32'h3FF, 1, 0, 0, 0, 32'h000);
        add(1, 1, 0, 0, 32'h3FF, 1, 0, 0, 0, 32'h3FF);
        add(1, 1, 0, 0, 32'h3FF, 0, 0, 10, 0, 32'h3FF);
      end else begin
        add(1, 1, 0, 0, 32'h3FF, 1, 1, 9, ev, 32'h1FF);
        add(1, 1, 0, 0, 32'h3FF, 1, 1, 9, ev, 32'h3FF);
        add(1, 1, 0, 0, 32'h3FF, 0, 1, 10, ev, 32'h3FF);
      end
      add(1, 1, 0, 0, 32'h3FF, 0, 1, 10, evn, 32'h3FF);
      add(1, 1, 0, 0, 32'h1FF, 0, 1, 10, evn, 32'h3FF);
      add(1, 1, 0, 0, 32'h1FF, 0, 1, 10, evn, 32'h1FF);
      add(2, 1, 0, 0, 32'h1FF, 1, 1, 9, evn, 32'h1FF);
      ev = evn;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      @(negedge clk);
      reset = r.rst;
      clear = r.clr;
      x0    = r.x[6:0];
      x1    = r.x[15:0];
      sb.push_back(r);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (!e.sel) begin
        check("f", i, 32'(f0), 32'(e.f));
        check("alarm", i, 32'(alarm0), 32'(e.al));
        check("count", i, 32'(count0), 32'(e.cnt));
        check("events", i, 32'(events0), 32'(e.ev));
        check("stable", i, 32'(stable0), e.st);
      end else begin
        check("f16", i, 32'(f1), 32'(e.f));
        check("alarm16", i, 32'(alarm1), 32'(e.al));
        check("count16", i, 32'(count1), 32'(e.cnt));
        check("events16", i, 32'(events1), 32'(e.ev));
        check("stable16", i, 32'(stable1), e.st);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
